// File: rtl/grid_scan_sync_pkg.sv
// Shared screen definitions: system and scan state encodings, default grid geometry.
package grid_scan_sync_pkg;

  localparam int GRID_ROWS = 9;
  localparam int GRID_COLS = 9;
  localparam int CELL_W    = 4;

  typedef enum logic [1:0] {
    SYS_BOOT,
    SYS_RUN,
    SYS_HALT
  } sys_state_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } scan_state_t;

endpackage

// File: rtl/grid_shadow.sv
// Shadow copy of the last value drawn per cell; flags cells whose live value differs.
module grid_shadow #(
  parameter int ROWS   = 9,
  parameter int COLS   = 9,
  parameter int DATA_W = 4,
  parameter int ROW_W  = $clog2(ROWS),
  parameter int COL_W  = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  input  logic [DATA_W-1:0] live_data,
  output logic              dirty
);

  // Contents are never reset; the parent forces a full frame until they are valid.
  logic [DATA_W-1:0] mem [ROWS][COLS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_row][wr_col] <= wr_data;
  end

  assign dirty = (mem[rd_row][rd_col] != live_data);

endmodule

// File: rtl/grid_scan_sync.sv
// Row-major grid scanner handing changed (or all) cells to the cell drawer over valid/ready.
//
// state | meaning
// IDLE  | waiting for scan_en; latches frame mode
// SCAN  | examining the cell under the pointer, one per cycle
// EMIT  | presenting a cell, holding until cell_ready
// DONE  | frame complete; frame_done pulses, shadow becomes valid
module grid_scan_sync
  import grid_scan_sync_pkg::*;
#(
  parameter int ROWS   = GRID_ROWS,
  parameter int COLS   = GRID_COLS,
  parameter int DATA_W = CELL_W,
  parameter int ROW_W  = $clog2(ROWS),
  parameter int COL_W  = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_en,
  input  logic              full_refresh,
  input  logic [DATA_W-1:0] display_grid [ROWS][COLS],
  output logic              cell_valid,
  input  logic              cell_ready,
  output logic [ROW_W-1:0]  cell_row,
  output logic [COL_W-1:0]  cell_col,
  output logic [DATA_W-1:0] cell_data,
  output logic              busy,
  output logic              frame_done
);

  scan_state_t       state, state_nx;
  logic [ROW_W-1:0]  ptr_row, ptr_row_nx, adv_row;
  logic [COL_W-1:0]  ptr_col, ptr_col_nx, adv_col;
  logic              mode_full, mode_full_nx;
  logic              shadow_valid, shadow_valid_nx;
  logic              valid_nx;
  logic [ROW_W-1:0]  row_nx;
  logic [COL_W-1:0]  col_nx;
  logic [DATA_W-1:0] data_nx;
  logic              sh_we;
  logic              cell_dirty;
  logic              last_cell;
  logic [DATA_W-1:0] live_data;

  assign live_data = display_grid[ptr_row][ptr_col];
  assign last_cell = (ptr_row == ROW_W'(ROWS - 1)) && (ptr_col == COL_W'(COLS - 1));

  always_comb begin
    adv_row = ptr_row;
    adv_col = ptr_col + COL_W'(1);
    if (ptr_col == COL_W'(COLS - 1)) begin
      adv_col = '0;
      adv_row = ptr_row + ROW_W'(1);
    end
  end

  // Writes the value actually drawn, so a grid change during the stall is caught next frame.
  grid_shadow #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .DATA_W (DATA_W),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W)
  ) u_shadow (
    .clk       (clk),
    .wr_en     (sh_we),
    .wr_row    (cell_row),
    .wr_col    (cell_col),
    .wr_data   (cell_data),
    .rd_row    (ptr_row),
    .rd_col    (ptr_col),
    .live_data (live_data),
    .dirty     (cell_dirty)
  );

  always_comb begin
    state_nx        = state;
    ptr_row_nx      = ptr_row;
    ptr_col_nx      = ptr_col;
    mode_full_nx    = mode_full;
    shadow_valid_nx = shadow_valid;
    valid_nx        = cell_valid;
    row_nx          = cell_row;
    col_nx          = cell_col;
    data_nx         = cell_data;
    sh_we           = 1'b0;
    case (state)
      IDLE: begin
        if (scan_en) begin
          mode_full_nx = full_refresh | ~shadow_valid;
          ptr_row_nx   = '0;
          ptr_col_nx   = '0;
          state_nx     = SCAN;
        end
      end
      SCAN: begin
        if (mode_full || cell_dirty) begin
          valid_nx = 1'b1;
          row_nx   = ptr_row;
          col_nx   = ptr_col;
          data_nx  = live_data;
          state_nx = EMIT;
        end else if (last_cell) begin
          state_nx = DONE;
        end else begin
          ptr_row_nx = adv_row;
          ptr_col_nx = adv_col;
        end
      end
      EMIT: begin
        if (cell_ready) begin
          sh_we    = 1'b1;
          valid_nx = 1'b0;
          if (last_cell) begin
            state_nx = DONE;
          end else begin
            ptr_row_nx = adv_row;
            ptr_col_nx = adv_col;
            state_nx   = SCAN;
          end
        end
      end
      DONE: begin
        shadow_valid_nx = 1'b1;
        state_nx        = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr_row      <= '0;
      ptr_col      <= '0;
      mode_full    <= 1'b1;
      shadow_valid <= 1'b0;
      cell_valid   <= 1'b0;
      cell_row     <= '0;
      cell_col     <= '0;
      cell_data    <= '0;
    end else begin
      state        <= state_nx;
      ptr_row      <= ptr_row_nx;
      ptr_col      <= ptr_col_nx;
      mode_full    <= mode_full_nx;
      shadow_valid <= shadow_valid_nx;
      cell_valid   <= valid_nx;
      cell_row     <= row_nx;
      cell_col     <= col_nx;
      cell_data    <= data_nx;
    end
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_grid_scan_sync.sv
// Directed bench for grid_scan_sync: a 9x9x4 instance and a 4x4x2 instance.
module tb_grid_scan_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scan_en = 1'b0;
  logic full_refresh = 1'b0;
  logic ready = 1'b1;
  logic sel = 1'b0;

  logic [3:0] grid_a [9][9];
  logic [1:0] grid_b [4][4];

  logic       a_valid, a_busy, a_done;
  logic [3:0] a_row, a_col, a_data;
  logic       b_valid, b_busy, b_done;
  logic [1:0] b_row, b_col, b_data;

  logic       cur_valid, cur_busy, cur_done;
  logic [3:0] cur_row, cur_col, cur_data;

  int n_tests = 0;
  int n_fail  = 0;
  int xr[$];
  int xc[$];
  int xd[$];

  always #5 clk = ~clk;

  grid_scan_sync #(.ROWS(9), .COLS(9), .DATA_W(4)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .scan_en      (scan_en & ~sel),
    .full_refresh (full_refresh),
    .display_grid (grid_a),
    .cell_valid   (a_valid),
    .cell_ready   (ready),
    .cell_row     (a_row),
    .cell_col     (a_col),
    .cell_data    (a_data),
    .busy         (a_busy),
    .frame_done   (a_done)
  );

  grid_scan_sync #(.ROWS(4), .COLS(4), .DATA_W(2)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .scan_en      (scan_en & sel),
    .full_refresh (full_refresh),
    .display_grid (grid_b),
    .cell_valid   (b_valid),
    .cell_ready   (ready),
    .cell_row     (b_row),
    .cell_col     (b_col),
    .cell_data    (b_data),
    .busy         (b_busy),
    .frame_done   (b_done)
  );

  assign cur_valid = sel ? b_valid : a_valid;
  assign cur_busy  = sel ? b_busy  : a_busy;
  assign cur_done  = sel ? b_done  : a_done;
  assign cur_row   = sel ? {2'b00, b_row}  : a_row;
  assign cur_col   = sel ? {2'b00, b_col}  : a_col;
  assign cur_data  = sel ? {2'b00, b_data} : a_data;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_tests++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Starts a frame on the selected DUT and records every transfer until frame_done.
  // done_k is the number of cycles from the first SCAN cycle to frame_done (-1 on timeout).
  task automatic run_frame(output int done_k);
    int k;
    bit seen;
    xr.delete(); xc.delete(); xd.delete();
    @(negedge clk); scan_en = 1'b1;
    @(negedge clk); scan_en = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 2000) begin
      if (cur_valid && ready) begin
        xr.push_back(int'(cur_row));
        xc.push_back(int'(cur_col));
        xd.push_back(int'(cur_data));
      end
      if (cur_done) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    done_k = seen ? k : -1;
    check_eq("frame_done_seen", int'(seen), 1);
  endtask

  task automatic check_raster(input string tag, input int rows, input int cols);
    int errs;
    int r, c, d;
    errs = 0;
    for (int i = 0; i < xr.size() && i < rows * cols; i++) begin
      r = i / cols;
      c = i % cols;
      d = sel ? int'(grid_b[r][c]) : int'(grid_a[r][c]);
      if (xr[i] != r || xc[i] != c || xd[i] != d) errs++;
    end
    check_eq({tag, "_count"}, xr.size(), rows * cols);
    check_eq({tag, "_order_errs"}, errs, 0);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!cur_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_valid_seen"}, int'(cur_valid), 1);
  endtask

  initial begin
    int dk;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) grid_a[r][c] = 4'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) grid_b[r][c] = 2'd0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", int'(a_valid), 0);
    check_eq("rst_row",   int'(a_row),   0);
    check_eq("rst_col",   int'(a_col),   0);
    check_eq("rst_data",  int'(a_data),  0);
    check_eq("rst_busy",  int'(a_busy),  0);
    check_eq("rst_done",  int'(a_done),  0);

    // First frame after reset is forced full.
    sel = 1'b0; ready = 1'b1;
    run_frame(dk);
    check_raster("a_first", 9, 9);
    @(negedge clk);
    check_eq("a_first_done_pulse", int'(a_done), 0);
    check_eq("a_first_idle",       int'(a_busy), 0);

    run_frame(dk);
    check_eq("a_clean_count", xr.size(), 0);
    check_eq("a_clean_timing", dk, 81);

    grid_a[4][7] = 4'd5;
    run_frame(dk);
    check_eq("a_single_count", xr.size(), 1);
    check_eq("a_single_row",  (xr.size() > 0) ? xr[0] : -1, 4);
    check_eq("a_single_col",  (xc.size() > 0) ? xc[0] : -1, 7);
    check_eq("a_single_data", (xd.size() > 0) ? xd[0] : -1, 5);

    // Stall at (0,2) while the grid value changes underneath.
    grid_a[0][2] = 4'd3;
    ready = 1'b0;
    @(negedge clk); scan_en = 1'b1;
    @(negedge clk); scan_en = 1'b0;
    wait_valid("stall");
    check_eq("stall_row",  int'(a_row),  0);
    check_eq("stall_col",  int'(a_col),  2);
    check_eq("stall_data", int'(a_data), 3);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) grid_a[0][2] = 4'd7;
      @(negedge clk);
      check_eq("stall_hold_valid", int'(a_valid), 1);
      check_eq("stall_hold_pos",   int'({a_row, a_col}), 2);
      check_eq("stall_hold_data",  int'(a_data), 3);
    end
    ready = 1'b1;
    begin
      int k;
      k = 0;
      while (!a_done && k < 200) begin
        @(negedge clk);
        k++;
      end
      check_eq("stall_frame_done", int'(a_done), 1);
    end
    run_frame(dk);
    check_eq("restall_count", xr.size(), 1);
    check_eq("restall_pos",  (xr.size() > 0) ? xr[0] * 16 + xc[0] : -1, 2);
    check_eq("restall_data", (xd.size() > 0) ? xd[0] : -1, 7);

    full_refresh = 1'b1;
    run_frame(dk);
    full_refresh = 1'b0;
    check_raster("a_full", 9, 9);

    // Reset while presenting (3,3) with the drawer stalled.
    grid_a[3][3] = 4'd9;
    ready = 1'b0;
    @(negedge clk); scan_en = 1'b1;
    @(negedge clk); scan_en = 1'b0;
    wait_valid("rstemit");
    check_eq("rstemit_pos", int'({a_row, a_col}), 8'h33);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rstemit_valid", int'(a_valid), 0);
    check_eq("rstemit_row",   int'(a_row),   0);
    check_eq("rstemit_col",   int'(a_col),   0);
    check_eq("rstemit_busy",  int'(a_busy),  0);
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    run_frame(dk);
    check_raster("a_after_rst", 9, 9);

    // Small 4x4x2 instance.
    sel = 1'b1;
    run_frame(dk);
    check_raster("b_first", 4, 4);
    check_eq("b_last_cell", (xr.size() == 16) ? xr[15] * 16 + xc[15] : -1, 8'h33);
    grid_b[2][1] = 2'd3;
    run_frame(dk);
    check_eq("b_single_count", xr.size(), 1);
    check_eq("b_single_pos",  (xr.size() > 0) ? xr[0] * 16 + xc[0] : -1, 8'h21);
    check_eq("b_single_data", (xd.size() > 0) ? xd[0] : -1, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
